sim_uart_monitor: RTL and testbench
===================================

Name: sim_uart_monitor

Overview:
- Simulation-side consumer of the DUT UART output stream (`io_uart_out_valid` / `io_uart_out_ch`), instantiated in the testbench top next to the DUT.
- Buffers characters in a FIFO and drains them through a valid/ready port to the testbench printer.
- Scans the raw stream for the pass/fail trap strings and runs an inactivity watchdog.
- Produces sticky `done`/`pass`/`timeout` flags that the testbench uses to end the run; synthesizable for emulation targets.

Parameters:
- FIFO_DEPTH, 64, character FIFO entries; power of two, ≥ 2.
- TIMEOUT_CYCLES, 32'd1000000, idle cycles with no input character before `timeout` asserts; 0 disables the watchdog.

Ports:
- clock  input  1  sole clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  DUT UART character strobe.
- in_ch  input  8  DUT UART character.
- out_valid  output  1  FIFO head is valid.
- out_ch  output  8  FIFO head character.
- out_ready  input  1  printer consumes the head this cycle.
- done  output  1  sticky; pass, fail or timeout detected.
- pass  output  1  sticky; PASS string matched (valid when `done`).
- timeout  output  1  sticky; watchdog expired.
- overflow  output  1  sticky; at least one character was dropped.
- drop_cnt  output  16  count of dropped characters, saturating at 16'hFFFF.

Behaviour:
- Reset (synchronous, active-high):
  - Outputs: `out_valid`, `done`, `pass`, `timeout`, `overflow` all 0; `drop_cnt` = 0; `out_ch` = 8'h00.
  - Internal state: FIFO empty, matcher indices 0, watchdog counter 0.
  - Reset asserted mid-operation discards FIFO contents and all flags in the same cycle.
  - `in_valid` is ignored while `reset` is high.
- Accept: a character is taken on any cycle with `in_valid=1` and `reset=0`; there is no backpressure on the input.
- FIFO write:
  - Written if not full, or if full and a pop occurs in the same cycle (`out_valid & out_ready`).
  - Otherwise the character is dropped: `overflow` <= 1 and `drop_cnt` increments, saturating.
- FIFO latency:
  - A write into an empty FIFO makes `out_valid=1` with that character on the next cycle; there is no same-cycle bypass.
  - Pop occurs when `out_valid & out_ready`; `out_ch` is held stable while `out_valid=1` and `out_ready=0`.
- FIFO pointers:
  - log2(FIFO_DEPTH)+1-bit read and write pointers with wrap bit.
  - Full when indices are equal and wrap bits differ; empty when both are equal.
  - Simultaneous push and pop on an empty FIFO is impossible, because `out_valid=0` means there is no pop.
- Matcher:
  - Two independent index registers, one per string: PASS = "HIT GOOD TRAP" (13 chars), FAIL = "HIT BAD TRAP" (12 chars).
  - Sees every accepted character, including dropped ones.
  - On each character: if it equals `str[idx]`, then idx <= idx+1; else idx <= (char == 'H') ? 1 : 0.
  - The restart rule is exact because 'H' occurs only at position 0 in both strings.
  - On completing PASS: `done` <= 1 and `pass` <= 1 on the next cycle. On completing FAIL: `done` <= 1 and `pass` <= 0.
  - Once `done=1` the matcher freezes and the first verdict wins; later characters still enter the FIFO.
- Watchdog:
  - 32-bit counter, cleared on every accepted character, otherwise incremented while `done=0`.
  - When count reaches TIMEOUT_CYCLES-1 without a character: `timeout` <= 1, `done` <= 1, `pass` <= 0.
  - A character arriving on the expiry cycle clears the counter, and no timeout occurs.
  - The counter stops once `done=1`.
- Simultaneous events: if a match completes on the same cycle as watchdog expiry, the match wins; the accepted character clears the watchdog.

Decomposition:
- Package `sim_uart_pkg`:
  - PASS_STR and FAIL_STR as byte-array constants with their lengths PASS_LEN = 13 and FAIL_LEN = 12.
  - `uart_ch_t` (8-bit) typedef.
  - Matcher index width constant.
- Sub-module `sim_uart_fifo`: synchronous FIFO with push/pop/full/empty and registered head; parameterized by FIFO_DEPTH and data width.
- Matcher, watchdog and sticky flags live in the top of the block.

Test Plan:
- Stream "ab\n", `out_ready=1` -> `out_valid` first high one cycle after 'a', `out_ch` 8'h61, 8'h62, 8'h0A on consecutive cycles; `done=0`.
- Stream "xHHIT GOOD TRAP" -> `done=1` and `pass=1` one cycle after the final 'P'; later "HIT BAD TRAP" leaves `pass=1`.
- Stream "HIT BAD TRAP" -> `done=1`, `pass=0`, `timeout=0`.
- FIFO_DEPTH=4, `out_ready=0`, 6 characters -> first 4 retained in order; `overflow=1`, `drop_cnt`=2.
  - Then a push and pop on the same cycle while full is accepted.
- TIMEOUT_CYCLES=10, one character then idle -> `timeout=1` and `done=1` 10 cycles after the character.
  - A character arriving at the 9th idle cycle restarts the count.
- Reset pulse with 3 characters buffered and `overflow=1` -> next cycle `out_valid=0`, `overflow=0`, `drop_cnt`=0, matcher restarts from index 0.

Source files
------------

// File: rtl/sim_uart_pkg.sv
// Shared types and constants for the simulation UART monitor.
//   uart_ch_t             : one UART character
//   PASS_STR / FAIL_STR   : trap strings scanned for in the raw stream
//   IDX_W / idx_t         : matcher index width and type
//   match_next()          : one step of a prefix matcher for a string whose
//                           only 'H' is at position 0
package sim_uart_pkg;

    typedef logic [7:0] uart_ch_t;

    localparam int unsigned PASS_LEN = 13;
    localparam int unsigned FAIL_LEN = 12;
    localparam int unsigned IDX_W    = 4;

    typedef logic [IDX_W-1:0] idx_t;

    localparam uart_ch_t PASS_STR [PASS_LEN] =
        '{"H", "I", "T", " ", "G", "O", "O", "D", " ", "T", "R", "A", "P"};
    localparam uart_ch_t FAIL_STR [FAIL_LEN] =
        '{"H", "I", "T", " ", "B", "A", "D", " ", "T", "R", "A", "P"};

    localparam idx_t PASS_LAST = idx_t'(PASS_LEN - 1);
    localparam idx_t FAIL_LAST = idx_t'(FAIL_LEN - 1);

    // A mismatch can only restart on 'H' because 'H' appears nowhere else in
    // either string, so no deeper fallback is ever needed.
    function automatic idx_t match_next(input idx_t idx, input uart_ch_t ch,
                                        input uart_ch_t want, input idx_t last);
        if (ch == want) begin
            return (idx == last) ? '0 : idx + idx_t'(1);
        end
        return (ch == "H") ? idx_t'(1) : '0;
    endfunction

endpackage

// File: rtl/sim_uart_fifo.sv
// Synchronous character FIFO with wrap-bit pointers.
//   clk_i, rst_i    : clock, synchronous active-high reset
//   push_i, data_i  : write request; taken when not full or when popping
//   pop_i           : consume head (ignored when empty)
//   data_o          : head character, 0 while empty
//   full_o, empty_o : occupancy status
module sim_uart_fifo #(
    parameter int unsigned Depth = 64,
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned AW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             do_pop, do_push;

    always_comb begin
        empty_o = (wptr_q == rptr_q);
        full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        do_pop  = pop_i && !empty_o;
        // A pop frees the slot the write lands in, so full+pop still accepts.
        do_push = push_i && (!full_o || do_pop);
        wptr_d  = do_push ? wptr_q + (AW+1)'(1) : wptr_q;
        rptr_d  = do_pop  ? rptr_q + (AW+1)'(1) : rptr_q;
        data_o  = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset: it is only visible through a valid head.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/sim_uart_monitor.sv
// Simulation-side UART consumer: buffers the DUT character stream for the
// printer, scans it for the pass/fail trap strings and runs an idle watchdog.
//   clock, reset         : clock, synchronous active-high reset
//   in_valid, in_ch      : DUT character strobe and character (no backpressure)
//   out_valid, out_ch    : FIFO head towards the printer
//   out_ready            : printer consumes the head this cycle
//   done, pass, timeout  : sticky verdict flags
//   overflow, drop_cnt   : sticky drop flag and saturating drop count
module sim_uart_monitor
    import sim_uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 64,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_ch,
    output logic        out_valid,
    output logic [7:0]  out_ch,
    input  logic        out_ready,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic        overflow,
    output logic [15:0] drop_cnt
);
    logic        acc, pop, fifo_full, fifo_empty, drop;
    logic        pass_hit, fail_hit, wd_expire;
    idx_t        pass_idx_q, pass_idx_d, fail_idx_q, fail_idx_d;
    logic [31:0] wd_q, wd_d;
    logic        done_q, done_d, pass_q, pass_d, timeout_q, timeout_d;
    logic        overflow_q, overflow_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    sim_uart_fifo #(
        .Depth (FIFO_DEPTH),
        .Width (8)
    ) u_fifo (
        .clk_i   (clock),
        .rst_i   (reset),
        .push_i  (acc),
        .data_i  (in_ch),
        .pop_i   (pop),
        .data_o  (out_ch),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        acc       = in_valid && !reset;
        out_valid = !fifo_empty;
        pop       = out_valid && out_ready;
        drop      = acc && fifo_full && !pop;

        overflow_d = overflow_q || drop;
        drop_cnt_d = (drop && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;

        // Matcher sees every accepted character, dropped or not, until a verdict.
        pass_hit   = acc && !done_q && (in_ch == PASS_STR[pass_idx_q]) && (pass_idx_q == PASS_LAST);
        fail_hit   = acc && !done_q && (in_ch == FAIL_STR[fail_idx_q]) && (fail_idx_q == FAIL_LAST);
        pass_idx_d = pass_idx_q;
        fail_idx_d = fail_idx_q;
        if (acc && !done_q) begin
            pass_idx_d = match_next(pass_idx_q, in_ch, PASS_STR[pass_idx_q], PASS_LAST);
            fail_idx_d = match_next(fail_idx_q, in_ch, FAIL_STR[fail_idx_q], FAIL_LAST);
        end

        // An accepted character always clears the count, so it also blocks expiry.
        wd_expire = (TIMEOUT_CYCLES != 32'd0) && !done_q && !acc
                    && (wd_q == TIMEOUT_CYCLES - 32'd1);
        if (acc) begin
            wd_d = '0;
        end else if (!done_q) begin
            wd_d = wd_q + 32'd1;
        end else begin
            wd_d = wd_q;
        end

        done_d    = done_q;
        pass_d    = pass_q;
        timeout_d = timeout_q;
        if (pass_hit) begin
            done_d = 1'b1;
            pass_d = 1'b1;
        end else if (fail_hit) begin
            done_d = 1'b1;
            pass_d = 1'b0;
        end else if (wd_expire) begin
            done_d    = 1'b1;
            pass_d    = 1'b0;
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pass_idx_q <= '0;
            fail_idx_q <= '0;
            wd_q       <= '0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            timeout_q  <= 1'b0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            pass_idx_q <= pass_idx_d;
            fail_idx_q <= fail_idx_d;
            wd_q       <= wd_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            timeout_q  <= timeout_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign done     = done_q;
    assign pass     = pass_q;
    assign timeout  = timeout_q;
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_sim_uart_monitor.sv
module tb_sim_uart_monitor;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TMO   = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_ch;
    logic        out_valid;
    logic [7:0]  out_ch;
    logic        out_ready;
    logic        done, pass, timeout, overflow;
    logic [15:0] drop_cnt;

    int n_vec = 0;
    int n_bad = 0;

    sim_uart_monitor #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (32'(TMO))
    ) dut (
        .clock     (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ch     (in_ch),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .out_ready (out_ready),
        .done      (done),
        .pass      (pass),
        .timeout   (timeout),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // FIFO as a queue, matcher as "accepted history ends with the string",
    // watchdog as a count of consecutive idle cycles.
    byte unsigned mq[$];
    byte unsigned hist[$];
    bit           m_live = 0;
    bit           m_done, m_pass, m_to, m_ovf;
    int           m_drops, m_idle;

    function automatic bit ends_with(input string s);
        if (hist.size() < s.len()) return 1'b0;
        for (int i = 0; i < s.len(); i++) begin
            if (hist[hist.size() - s.len() + i] != s[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            hist.delete();
            m_done = 0; m_pass = 0; m_to = 0; m_ovf = 0;
            m_drops = 0; m_idle = 0;
            m_live = 1;
        end else if (m_live) begin
            if (mq.size() != 0 && out_ready) void'(mq.pop_front());
            if (in_valid) begin
                if (mq.size() < DEPTH) mq.push_back(in_ch);
                else begin
                    m_ovf = 1;
                    if (m_drops < 65535) m_drops++;
                end
                m_idle = 0;
                if (!m_done) begin
                    hist.push_back(in_ch);
                    if (hist.size() > 32) void'(hist.pop_front());
                    if (ends_with("HIT GOOD TRAP")) begin
                        m_done = 1; m_pass = 1;
                    end else if (ends_with("HIT BAD TRAP")) begin
                        m_done = 1; m_pass = 0;
                    end
                end
            end else if (!m_done) begin
                m_idle++;
                if (m_idle == TMO) begin
                    m_done = 1; m_pass = 0; m_to = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
            if (mq.size() != 0) check("out_ch", 32'(out_ch), 32'(mq[0]));
            check("done", 32'(done), 32'(m_done));
            check("pass", 32'(pass), 32'(m_pass));
            check("timeout", 32'(timeout), 32'(m_to));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("drop_cnt", 32'(drop_cnt), 32'(m_drops));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic send(input byte unsigned c);
        in_valid = 1'b1;
        in_ch    = c;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_ch = 8'h00; out_ready = 1'b0;
        tick(2);
        reset = 1'b0;

        // Reset state
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_ch", 32'(out_ch), 32'h00);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);

        // "ab\n" through the FIFO with the printer always ready
        out_ready = 1'b1;
        check("ab_pre_valid", 32'(out_valid), 32'd0);
        send(8'h61);
        check("ab_valid", 32'(out_valid), 32'd1);
        check("ab_ch_a", 32'(out_ch), 32'h61);
        send(8'h62);
        check("ab_ch_b", 32'(out_ch), 32'h62);
        send(8'h0A);
        check("ab_ch_nl", 32'(out_ch), 32'h0A);
        tick(1);
        check("ab_drained", 32'(out_valid), 32'd0);
        check("ab_done", 32'(done), 32'd0);

        // PASS string with a partial prefix in front; later FAIL is ignored
        do_reset();
        send_str("xHHIT GOOD TRA");
        check("pass_early_done", 32'(done), 32'd0);
        send("P");
        check("pass_done", 32'(done), 32'd1);
        check("pass_pass", 32'(pass), 32'd1);
        send_str("HIT BAD TRAP");
        check("pass_sticky", 32'(pass), 32'd1);
        check("pass_no_to", 32'(timeout), 32'd0);

        // FAIL string
        do_reset();
        send_str("HIT BAD TRAP");
        check("fail_done", 32'(done), 32'd1);
        check("fail_pass", 32'(pass), 32'd0);
        check("fail_timeout", 32'(timeout), 32'd0);

        // Overflow with the printer stalled, then push+pop while full
        do_reset();
        out_ready = 1'b0;
        send_str("ABCDEF");
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_drops", 32'(drop_cnt), 32'd2);
        check("ovf_head_A", 32'(out_ch), 32'h41);
        out_ready = 1'b1;
        send("G");
        out_ready = 1'b0;
        check("full_pp_head_B", 32'(out_ch), 32'h42);
        check("full_pp_drops", 32'(drop_cnt), 32'd2);
        out_ready = 1'b1;
        tick(1);
        check("drain_C", 32'(out_ch), 32'h43);
        tick(1);
        check("drain_D", 32'(out_ch), 32'h44);
        tick(1);
        check("drain_G", 32'(out_ch), 32'h47);
        tick(1);
        check("drain_empty", 32'(out_valid), 32'd0);

        // Watchdog: restart on the 9th idle cycle and on the expiry cycle
        do_reset();
        send("z");
        tick(8);
        send("y");
        check("wd_restart9", 32'(timeout), 32'd0);
        tick(9);
        send("w");
        check("wd_restart_exp", 32'(timeout), 32'd0);
        check("wd_restart_done", 32'(done), 32'd0);
        tick(9);
        check("wd_pre_expire", 32'(done), 32'd0);
        tick(1);
        check("wd_timeout", 32'(timeout), 32'd1);
        check("wd_done", 32'(done), 32'd1);
        check("wd_pass", 32'(pass), 32'd0);
        send_str("HIT GOOD TRAP");
        check("wd_first_wins", 32'(pass), 32'd0);

        // Reset mid-stream discards buffer, flags and matcher progress
        do_reset();
        out_ready = 1'b0;
        send_str("HIT B");
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        check("mid_pre_ovf", 32'(overflow), 32'd1);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_ch    = "X";
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        check("mid_valid", 32'(out_valid), 32'd0);
        check("mid_ovf", 32'(overflow), 32'd0);
        check("mid_drops", 32'(drop_cnt), 32'd0);
        out_ready = 1'b1;
        send_str("AD TRAP");
        check("mid_matcher_cleared", 32'(done), 32'd0);
        send_str("HIT GOOD TRAP");
        check("mid_pass", 32'(pass), 32'd1);
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
